// File: rtl/sigma0_inverse.sv
// Iterative inverse of the SHA-256 big-sigma-0 mix. S0 has order 16 up to a rotation
// (S0^16 == ROTR16), so x = ROTR16(S0^15(y)); UNROLL sets the S0 applications per clock.
module sigma0_inverse #(
    parameter int UNROLL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    generate
        if (!(UNROLL == 1 || UNROLL == 3 || UNROLL == 5 || UNROLL == 15)) begin : g_bad_unroll
            $error("sigma0_inverse: UNROLL must be 1, 3, 5 or 15");
        end
    endgenerate

    localparam logic [4:0] STEP = 5'(UNROLL);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [31:0] rotr(input logic [31:0] v, input int unsigned n);
        return (v >> n) | (v << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] v);
        return rotr(v, 2) ^ rotr(v, 13) ^ rotr(v, 22);
    endfunction

    function automatic logic [31:0] s0_pow(input logic [31:0] v);
        logic [31:0] r;
        r = v;
        for (int k = 0; k < UNROLL; k++) begin
            r = s0(r);
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    logic [31:0] mixed_s;
    logic [4:0]  count_next_s;

    assign mixed_s      = s0_pow(acc_q);
    assign count_next_s = {1'b0, count_q} + STEP;

    // Next-state and registered-output decode for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    acc_d      = in_data;
                    count_d    = 4'd0;
                    state_d    = ST_RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // The last batch of S0 rounds feeds the output rotation directly.
                if (count_next_s == 5'd15) begin
                    out_data_d  = rotr(mixed_s, 16);
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    acc_d   = mixed_s;
                    count_d = count_next_s[3:0];
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= 32'd0;
            count_q     <= 4'd0;
            out_data_q  <= 32'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sigma0_inverse.sv
// Bench for sigma0_inverse: four instances (UNROLL 1/3/5/15) checked against a scoreboard
// that knows the preimage x of every driven word y = S0(x).
module tb_sigma0_inverse;

    localparam int NI = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid_s  [NI];
    logic        in_ready_s  [NI];
    logic [31:0] in_data_s   [NI];
    logic        out_valid_s [NI];
    logic        out_ready_s [NI];
    logic [31:0] out_data_s  [NI];
    logic        busy_s      [NI];
    logic [31:0] in_x        [NI];

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    logic [31:0] exp_val  [NI];
    int          exp_n    [NI];
    int          hs_cyc   [NI];
    logic        prev_ov  [NI];
    int          out_cnt  [NI];
    logic        b2b = 1'b0;
    int          last_acc = -1;

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            sigma0_inverse #(.UNROLL(g == 0 ? 1 : g == 1 ? 3 : g == 2 ? 5 : 15)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid_s[g]),
                .in_ready  (in_ready_s[g]),
                .in_data   (in_data_s[g]),
                .out_valid (out_valid_s[g]),
                .out_ready (out_ready_s[g]),
                .out_data  (out_data_s[g]),
                .busy      (busy_s[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unroll_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            2:       return 5;
            default: return 15;
        endcase
    endfunction

    // Reference S0 straight from its definition, using a doubled word for the rotates.
    function automatic logic [31:0] rot_ref(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] s0_ref(input logic [31:0] x);
        return rot_ref(x, 2) ^ rot_ref(x, 13) ^ rot_ref(x, 22);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s (inst %0d): actual %h required %h", name, idx, act, req);
        end
    endtask

    // Scoreboard/compare process: every cycle, every instance.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                exp_n[i]   = 0;
                prev_ov[i] = 1'b0;
                chk("reset_in_ready", i, 32'(in_ready_s[i]), 32'd1);
                chk("reset_out_valid", i, 32'(out_valid_s[i]), 32'd0);
                chk("reset_out_data", i, out_data_s[i], 32'd0);
                chk("reset_busy", i, 32'(busy_s[i]), 32'd0);
            end else begin
                chk("busy_vs_in_ready", i, 32'(busy_s[i]), 32'(!in_ready_s[i]));
                if (exp_n[i] == 0) begin
                    chk("out_valid_without_input", i, 32'(out_valid_s[i]), 32'd0);
                end
                if (out_valid_s[i] && exp_n[i] != 0) begin
                    chk("out_data", i, out_data_s[i], exp_val[i]);
                    chk("in_ready_while_done", i, 32'(in_ready_s[i]), 32'd0);
                    if (!prev_ov[i]) begin
                        chk("latency", i, 32'(cyc - hs_cyc[i]), 32'(15 / unroll_of(i)));
                    end
                    if (out_ready_s[i]) begin
                        exp_n[i] = 0;
                        out_cnt[i]++;
                    end
                end
                if (in_valid_s[i] && in_ready_s[i]) begin
                    chk("one_in_flight", i, 32'(exp_n[i]), 32'd0);
                    exp_val[i] = in_x[i];
                    exp_n[i]   = 1;
                    hs_cyc[i]  = cyc + 1;
                    if (i == 0 && b2b && last_acc >= 0) begin
                        chk("b2b_spacing", i, 32'(hs_cyc[0] - last_acc), 32'd17);
                    end
                    if (i == 0) last_acc = hs_cyc[0];
                end
                prev_ov[i] = out_valid_s[i];
            end
            if (!b2b) last_acc = -1;
        end
    end

    task automatic drive_word(input int i, input logic [31:0] x, input logic [31:0] y);
        int n;
        @(posedge clk); #1;
        in_x[i]       = x;
        in_data_s[i]  = y;
        in_valid_s[i] = 1'b1;
        n = 0;
        while (!in_ready_s[i] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_timeout", i, 32'(n < 200), 32'd1);
        @(posedge clk); #1;
        in_valid_s[i] = 1'b0;
        in_data_s[i]  = $urandom;
    endtask

    task automatic wait_out(input int i, output int n);
        n = 0;
        while (!out_valid_s[i] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("out_timeout", i, 32'(n < 100), 32'd1);
    endtask

    task automatic take_out(input int i);
        out_ready_s[i] = 1'b1;
        @(posedge clk); #1;
        out_ready_s[i] = 1'b0;
        chk("out_valid_after_handshake", i, 32'(out_valid_s[i]), 32'd0);
    endtask

    task automatic directed(input logic [31:0] x, input logic [31:0] y);
        int n;
        drive_word(0, x, y);
        wait_out(0, n);
        chk("latency_u1", 0, 32'(n), 32'd15);
        chk("directed_out", 0, out_data_s[0], x);
        take_out(0);
    endtask

    task automatic stream(input int i, input int nw);
        logic [31:0] x;
        int n;
        logic hs;
        logic done;
        for (int w = 0; w < nw; w++) begin
            x = $urandom;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            drive_word(i, x, s0_ref(x));
            n = 0;
            done = 1'b0;
            while (!done && n < 400) begin
                out_ready_s[i] = ($urandom_range(0, 3) != 0);
                hs = out_valid_s[i] && out_ready_s[i];
                @(posedge clk); #1;
                done = hs;
                n++;
            end
            out_ready_s[i] = 1'b0;
            chk("stream_timeout", i, 32'(done), 32'd1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c0;
        rst_n = 1'b1;
        for (int i = 0; i < NI; i++) begin
            in_valid_s[i]  = 1'b0;
            in_data_s[i]   = 32'd0;
            out_ready_s[i] = 1'b0;
            in_x[i]        = 32'd0;
            exp_n[i]       = 0;
            exp_val[i]     = 32'd0;
            hs_cyc[i]      = 0;
            prev_ov[i]     = 1'b0;
            out_cnt[i]     = 0;
        end
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("model_pin_s0_1", 0, s0_ref(32'h0000_0001), 32'h4008_0400);
        chk("model_pin_s0_msb", 0, s0_ref(32'h8000_0000), 32'h2004_0200);

        directed(32'h0000_0001, 32'h4008_0400);
        directed(32'h8000_0000, 32'h2004_0200);
        directed(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        directed(32'h0000_0000, 32'h0000_0000);

        // Back-pressure: hold out_ready low while the next word waits upstream.
        drive_word(0, 32'h1234_5678, s0_ref(32'h1234_5678));
        wait_out(0, n);
        in_x[0]       = 32'hCAFE_F00D;
        in_data_s[0]  = s0_ref(32'hCAFE_F00D);
        in_valid_s[0] = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            chk("bp_in_ready", 0, 32'(in_ready_s[0]), 32'd0);
            chk("bp_out_valid", 0, 32'(out_valid_s[0]), 32'd1);
            chk("bp_out_data", 0, out_data_s[0], 32'h1234_5678);
        end
        take_out(0);
        chk("bp_ready_after_out", 0, 32'(in_ready_s[0]), 32'd1);
        @(posedge clk); #1;
        in_valid_s[0] = 1'b0;
        chk("bp_next_accepted", 0, 32'(in_ready_s[0]), 32'd0);
        wait_out(0, n);
        chk("bp_next_data", 0, out_data_s[0], 32'hCAFE_F00D);
        take_out(0);

        // Reset in the seventh RUN cycle discards the word.
        drive_word(0, 32'h0BAD_BEEF, s0_ref(32'h0BAD_BEEF));
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_in_ready", 0, 32'(in_ready_s[0]), 32'd1);
        chk("rst_mid_out_valid", 0, 32'(out_valid_s[0]), 32'd0);
        chk("rst_mid_out_data", 0, out_data_s[0], 32'd0);
        chk("rst_mid_busy", 0, 32'(busy_s[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (25) @(posedge clk);
        directed(32'h0000_0001, 32'h4008_0400);

        // Back-to-back stream with out_ready tied high.
        b2b = 1'b1;
        out_ready_s[0] = 1'b1;
        c0 = out_cnt[0];
        for (int w = 0; w < 6; w++) begin
            drive_word(0, 32'h1111_1111 * (w + 1), s0_ref(32'h1111_1111 * (w + 1)));
        end
        n = 0;
        while (!in_ready_s[0] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk);
        chk("b2b_word_count", 0, 32'(out_cnt[0] - c0), 32'd6);
        @(posedge clk); #1;
        out_ready_s[0] = 1'b0;
        b2b = 1'b0;

        // Randomized words on all four unroll variants in parallel.
        for (int i = 0; i < NI; i++) begin
            fork
                automatic int k = i;
                stream(k, 1500);
            join_none
        end
        wait fork;

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
